alufu_buffered: RTL and testbench
=================================

# alufu_buffered

Parametrised ALU functional unit for the out-of-order core, successor to the fixed 8-bit ALU FU. It accepts issued ALU micro-ops from the reservation station and computes the result. Results are queued in a DEPTH-entry in-order result buffer, and each entry is delivered independently to the CDB and to the ROB, each with its own stall. An entry retires only when both consumers have taken it.

## Interface
- XLEN, 8, operand/result width; a power of two and at least 8.
- ROBID_W, 4, ROB tag width.
- WB_W, 8, writeback-descriptor width, carried opaquely.
- FLAG_W, 8, flags width; at least 4.
- DEPTH, 2, result-buffer entries; a power of two and at least 2.
- clk  in  1  clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- input_transmit  in  1  issue valid.
- operand  in  8  [3:0] op class, must be 4'h4 for ALU; [7:4] function code.
- depvals  in  [1:0][XLEN]  depvals[1]=A, depvals[0]=B.
- wbs  in  WB_W  writeback descriptor.
- flags  in  FLAG_W  decode flags.
- robid  in  ROBID_W  ROB tag.
- cdb_transmit  in  1  CDB occupied by another unit this cycle (stall).
- cdb_transmit_out  out  1  driving the CDB.
- cdb_id  out  ROBID_W  CDB tag.
- cdb_val  out  XLEN  CDB value.
- rob_transmit  in  1  ROB write port occupied (stall).
- rob_transmit_out  out  1  driving the ROB.
- robid_out  out  ROBID_W  ROB tag out.
- flags_out  out  FLAG_W  flags out.
- wbs_out  out  WB_W  writeback descriptor out.
- value_out  out  XLEN  result to the ROB.
- busy  out  1  result buffer full.

## Operation
- Function codes:
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR.
  - 5 SHL, 6 SHR logical, 7 SRA; shift amount is B[$clog2(XLEN)-1:0].
  - 8 SLT signed, 9 SLTU; both return 1 or 0.
  - 10–15 return 0.
- Arithmetic wraps modulo 2^XLEN.
- Accept condition: input_transmit=1, busy=0 and class=4'h4.
  - An accepted op computes combinationally and its entry is written at the tail on that edge.
  - A non-ALU class is ignored.
  - input_transmit while busy is a protocol violation; the op is dropped and state is unchanged.
- Each entry holds {value, robid, wbs, flags, cdb_done, rob_done}.
- Only the head entry is presented, which preserves order on both buses.
  - cdb_transmit_out = head_valid & ~cdb_done.
  - rob_transmit_out = head_valid & ~rob_done.
- Transfer rules:
  - A CDB transfer happens on an edge where cdb_transmit_out=1 and cdb_transmit=0; it sets cdb_done. The ROB rule is symmetric.
  - The head pops when both done flags are set or are being set on that edge, including both in the same cycle.
- Empty buffer: all data outputs drive 0.
- busy = (count == DEPTH), combinational from the registered count. A pop and a push in the same cycle are legal only when not full.
- Reset: the buffer empties and all outputs are 0, including busy. Entries in flight at reset are discarded.

## Timing
- Latency: an op accepted at edge N is presented to both buses in cycle N+1 and pops at edge N+1 if neither bus stalls.
- Throughput: one op per cycle with no stalls.
- A stalled bus holds the head; the other bus does not advance past the head.
- Pointers wrap modulo DEPTH.

## Configuration
- ALUFU_FLAGS_EN defined: flags_out = {stored flags[FLAG_W-1:4], V, C, N, Z}, computed from the result.
  - Z: result is zero.
  - N: result MSB.
  - C: carry-out on ADD; borrow (A<B unsigned) on SUB; 0 for other ops.
  - V: signed overflow on ADD/SUB; 0 for other ops.
- Not defined: flags_out passes the input flags through unchanged.

## Structure
- Package alufu_pkg holds:
  - ALU_CLASS = 4'h4.
  - alu_fn_e, the function-code enum.
  - FLAG_Z/N/C/V bit indices.
- The entry struct is declared locally, because its widths depend on the parameters.
- Sub-module alufu_core: purely combinational compute of the result and, under the macro, the VCNZ bits.

## Test plan
- ADD: reset, then 0x04 with {10,20}, robid 1, wbs A1 -> next cycle both *_transmit_out=1, cdb_val=value_out=30, cdb_id=1, wbs_out=A1; the buffer is empty the following cycle.
- SUB borrow flags: 0x14 with {5,6} -> value FF. With ALUFU_FLAGS_EN and flags=F0, flags_out=F6; without the macro, flags_out=F0.
- Split stall: rob_transmit=1 for 3 cycles, cdb_transmit=0 -> CDB is taken in cycle 1 and cdb_transmit_out drops. rob_transmit_out holds the value and the entry pops on the first edge with rob_transmit=0.
- Full buffer (DEPTH=2): both buses stalled while issuing ADD {1,2}, SUB {10,5}, ADD {7,7} back-to-back -> busy=1 after two ops and the third is dropped. On release, 3 then 5 appear in order and nothing follows.
- Misc ops:
  - 0x44 {F0,FF} -> 0F.
  - 0x54 {81,1} -> 02.
  - 0x64 {81,1} -> 40.
  - 0x74 {81,1} -> C0.
  - 0x84 {FF,01} -> 01.
  - 0x05 -> no entry.
- Async reset: with two entries queued, raise rst mid-cycle -> all outputs 0 and busy 0 immediately, and the buffer is empty after release.

Source files
------------

// File: rtl/alufu_pkg.sv
// alufu_pkg: shared constants, function-code enum and flag bit indices for the buffered ALU FU
package alufu_pkg;
    localparam logic [3:0] ALU_CLASS = 4'h4;
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_AND  = 4'd2,
        FN_OR   = 4'd3,
        FN_XOR  = 4'd4,
        FN_SHL  = 4'd5,
        FN_SHR  = 4'd6,
        FN_SRA  = 4'd7,
        FN_SLT  = 4'd8,
        FN_SLTU = 4'd9
    } alu_fn_e;
endpackage

// File: rtl/alufu_buffered_if.sv
// alufu_buffered_if: issue inputs plus CDB/ROB delivery signals of the buffered ALU FU
interface alufu_buffered_if #(
    parameter int XLEN    = 8,
    parameter int ROBID_W = 4,
    parameter int WB_W    = 8,
    parameter int FLAG_W  = 8
);
    logic                      input_transmit;
    logic [7:0]                operand;
    logic [1:0][XLEN-1:0]      depvals;
    logic [WB_W-1:0]           wbs;
    logic [FLAG_W-1:0]         flags;
    logic [ROBID_W-1:0]        robid;
    logic                      cdb_transmit;
    logic                      cdb_transmit_out;
    logic [ROBID_W-1:0]        cdb_id;
    logic [XLEN-1:0]           cdb_val;
    logic                      rob_transmit;
    logic                      rob_transmit_out;
    logic [ROBID_W-1:0]        robid_out;
    logic [FLAG_W-1:0]         flags_out;
    logic [WB_W-1:0]           wbs_out;
    logic [XLEN-1:0]           value_out;
    logic                      busy;
    modport slave (
        input  input_transmit, operand, depvals, wbs, flags, robid, cdb_transmit, rob_transmit,
        output cdb_transmit_out, cdb_id, cdb_val, rob_transmit_out, robid_out, flags_out,
               wbs_out, value_out, busy
    );
    modport master (
        output input_transmit, operand, depvals, wbs, flags, robid, cdb_transmit, rob_transmit,
        input  cdb_transmit_out, cdb_id, cdb_val, rob_transmit_out, robid_out, flags_out,
               wbs_out, value_out, busy
    );
endinterface

// File: rtl/alufu_core.sv
// alufu_core: combinational ALU result and, with ALUFU_FLAGS_EN, the V/C/N/Z bits
module alufu_core import alufu_pkg::*; #(
    parameter int XLEN = 8
) (
    input  logic [3:0]      fn_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
`ifdef ALUFU_FLAGS_EN
    output logic [3:0]      vcnz_o,
`endif
    output logic [XLEN-1:0] res_o
);
    localparam int SH = $clog2(XLEN);
    logic [SH-1:0] sh;
    assign sh = b_i[SH-1:0];
    // result select by function code; unused codes yield zero
    always_comb begin
        case (fn_i)
            FN_ADD:  res_o = a_i + b_i;
            FN_SUB:  res_o = a_i - b_i;
            FN_AND:  res_o = a_i & b_i;
            FN_OR:   res_o = a_i | b_i;
            FN_XOR:  res_o = a_i ^ b_i;
            FN_SHL:  res_o = a_i << sh;
            FN_SHR:  res_o = a_i >> sh;
            FN_SRA:  res_o = $signed(a_i) >>> sh;
            FN_SLT:  res_o = XLEN'($signed(a_i) < $signed(b_i));
            FN_SLTU: res_o = XLEN'(a_i < b_i);
            default: res_o = '0;
        endcase
    end
`ifdef ALUFU_FLAGS_EN
    logic [XLEN:0] sum;
    logic          ms_a, ms_b, ms_r;
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign ms_a = a_i[XLEN-1];
    assign ms_b = b_i[XLEN-1];
    assign ms_r = res_o[XLEN-1];
    // carry is borrow on SUB; overflow when operand signs demand a sign the result lacks
    always_comb begin
        vcnz_o         = '0;
        vcnz_o[FLAG_Z] = res_o == '0;
        vcnz_o[FLAG_N] = ms_r;
        vcnz_o[FLAG_C] = fn_i == FN_ADD ? sum[XLEN] : fn_i == FN_SUB ? a_i < b_i : 1'b0;
        vcnz_o[FLAG_V] = fn_i == FN_ADD ? (ms_a == ms_b) && (ms_r != ms_a) :
                         fn_i == FN_SUB ? (ms_a != ms_b) && (ms_r != ms_a) : 1'b0;
    end
`endif
endmodule

// File: rtl/alufu_buffered.sv
// alufu_buffered: ALU FU with an in-order result buffer delivered separately to CDB and ROB (option ALUFU_FLAGS_EN)
module alufu_buffered import alufu_pkg::*; #(
    parameter int XLEN    = 8,
    parameter int ROBID_W = 4,
    parameter int WB_W    = 8,
    parameter int FLAG_W  = 8,
    parameter int DEPTH   = 2
) (
    input logic           clk,
    input logic           rst,
    alufu_buffered_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef struct packed {
        logic [XLEN-1:0]    value;
        logic [ROBID_W-1:0] robid;
        logic [WB_W-1:0]    wbs;
        logic [FLAG_W-1:0]  flags;
        logic               cdb_done;
        logic               rob_done;
    } entry_t;
    entry_t          ent_q [DEPTH];
    entry_t          ent_d [DEPTH];
    logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          head, new_ent;
    logic [XLEN-1:0] res;
    logic [FLAG_W-1:0] fl;
    logic            head_valid, cdb_xfer, rob_xfer, pop, push;
    alufu_core #(.XLEN(XLEN)) u_core (
        .fn_i   (bus.operand[7:4]),
        .a_i    (bus.depvals[1]),
        .b_i    (bus.depvals[0]),
`ifdef ALUFU_FLAGS_EN
        .vcnz_o (fl[3:0]),
`endif
        .res_o  (res)
    );
`ifdef ALUFU_FLAGS_EN
    assign fl[FLAG_W-1:4] = bus.flags[FLAG_W-1:4];
`else
    assign fl = bus.flags;
`endif
    assign head       = ent_q[head_q];
    assign head_valid = count_q != '0;
    assign bus.busy   = count_q == CW'(DEPTH);
    assign push       = bus.input_transmit & ~bus.busy & (bus.operand[3:0] == ALU_CLASS);
    assign bus.cdb_transmit_out = head_valid & ~head.cdb_done;
    assign bus.rob_transmit_out = head_valid & ~head.rob_done;
    assign cdb_xfer   = bus.cdb_transmit_out & ~bus.cdb_transmit;
    assign rob_xfer   = bus.rob_transmit_out & ~bus.rob_transmit;
    assign pop        = head_valid & (head.cdb_done | cdb_xfer) & (head.rob_done | rob_xfer);
    assign new_ent    = '{value: res, robid: bus.robid, wbs: bus.wbs, flags: fl, cdb_done: 1'b0, rob_done: 1'b0};
    assign bus.value_out = head_valid ? head.value : '0;
    assign bus.cdb_val   = bus.value_out;
    assign bus.robid_out = head_valid ? head.robid : '0;
    assign bus.cdb_id    = bus.robid_out;
    assign bus.wbs_out   = head_valid ? head.wbs : '0;
    assign bus.flags_out = head_valid ? head.flags : '0;
    // head either pops or records which consumer took it; accepted ops land at the tail
    always_comb begin
        ent_d   = ent_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (pop) begin
            head_d = head_q + AW'(1);
        end else begin
            if (cdb_xfer) ent_d[head_q].cdb_done = 1'b1;
            if (rob_xfer) ent_d[head_q].rob_done = 1'b1;
        end
        if (push) begin
            ent_d[tail_q] = new_ent;
            tail_d        = tail_q + AW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end
    // buffer state; reset discards everything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            ent_q   <= ent_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_alufu_buffered.sv
// tb_alufu_buffered: directed checks of the buffered ALU FU (expectations follow ALUFU_FLAGS_EN)
module tb_alufu_buffered;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;
    alufu_buffered_if #(.XLEN(8), .ROBID_W(4), .WB_W(8), .FLAG_W(8)) bus ();
    alufu_buffered #(.XLEN(8), .ROBID_W(4), .WB_W(8), .FLAG_W(8), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic issue(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] rid, input logic [7:0] wb, input logic [7:0] fl);
        bus.input_transmit = 1'b1;
        bus.operand        = op;
        bus.depvals[1]     = a;
        bus.depvals[0]     = b;
        bus.robid          = rid;
        bus.wbs            = wb;
        bus.flags          = fl;
        step();
        bus.input_transmit = 1'b0;
    endtask
    task automatic chk_empty(input string tag);
        chk({tag, "_cdb_out"}, 32'(bus.cdb_transmit_out), 0);
        chk({tag, "_rob_out"}, 32'(bus.rob_transmit_out), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_value"}, 32'(bus.value_out), 0);
    endtask
    task automatic op_chk(input string tag, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp);
        issue(op, a, b, 4'd9, 8'h00, 8'h00);
        chk({tag, "_present"}, 32'(bus.cdb_transmit_out), 1);
        chk(tag, 32'(bus.cdb_val), 32'(exp));
        step();
    endtask
    initial begin
        bus.input_transmit = 1'b0;
        bus.operand        = '0;
        bus.depvals        = '0;
        bus.robid          = '0;
        bus.wbs            = '0;
        bus.flags          = '0;
        bus.cdb_transmit   = 1'b0;
        bus.rob_transmit   = 1'b0;
        step();
        step();
        chk_empty("reset");
        chk("reset_flags", 32'(bus.flags_out), 0);
        rst = 1'b0;
        step();
        issue(8'h04, 8'd10, 8'd20, 4'd1, 8'hA1, 8'h00);
        chk("add_cdb_out", 32'(bus.cdb_transmit_out), 1);
        chk("add_rob_out", 32'(bus.rob_transmit_out), 1);
        chk("add_cdb_val", 32'(bus.cdb_val), 30);
        chk("add_value", 32'(bus.value_out), 30);
        chk("add_cdb_id", 32'(bus.cdb_id), 1);
        chk("add_robid", 32'(bus.robid_out), 1);
        chk("add_wbs", 32'(bus.wbs_out), 32'hA1);
        chk("add_flags", 32'(bus.flags_out), 0);
        step();
        chk_empty("add_after");
        issue(8'h14, 8'd5, 8'd6, 4'd2, 8'hB2, 8'hF0);
        chk("sub_value", 32'(bus.value_out), 32'hFF);
`ifdef ALUFU_FLAGS_EN
        chk("sub_flags", 32'(bus.flags_out), 32'hF6);
`else
        chk("sub_flags", 32'(bus.flags_out), 32'hF0);
`endif
        step();
        issue(8'h04, 8'h7F, 8'h01, 4'd3, 8'h00, 8'h00);
        chk("ovf_value", 32'(bus.value_out), 32'h80);
`ifdef ALUFU_FLAGS_EN
        chk("ovf_flags", 32'(bus.flags_out), 32'h0A);
`else
        chk("ovf_flags", 32'(bus.flags_out), 32'h00);
`endif
        step();
        issue(8'h04, 8'hFF, 8'h01, 4'd3, 8'h00, 8'h30);
        chk("carry_value", 32'(bus.value_out), 32'h00);
`ifdef ALUFU_FLAGS_EN
        chk("carry_flags", 32'(bus.flags_out), 32'h35);
`else
        chk("carry_flags", 32'(bus.flags_out), 32'h30);
`endif
        step();
        chk_empty("flags_after");
        bus.rob_transmit = 1'b1;
        issue(8'h04, 8'd3, 8'd4, 4'd3, 8'hC3, 8'h00);
        chk("split_c1_cdb", 32'(bus.cdb_transmit_out), 1);
        chk("split_c1_rob", 32'(bus.rob_transmit_out), 1);
        step();
        chk("split_c2_cdb", 32'(bus.cdb_transmit_out), 0);
        chk("split_c2_rob", 32'(bus.rob_transmit_out), 1);
        chk("split_c2_val", 32'(bus.value_out), 7);
        step();
        chk("split_c3_cdb", 32'(bus.cdb_transmit_out), 0);
        chk("split_c3_rob", 32'(bus.rob_transmit_out), 1);
        bus.rob_transmit = 1'b0;
        step();
        chk_empty("split_pop");
        bus.cdb_transmit = 1'b1;
        bus.rob_transmit = 1'b1;
        issue(8'h04, 8'd1, 8'd2, 4'd4, 8'h00, 8'h00);
        chk("full_busy1", 32'(bus.busy), 0);
        issue(8'h14, 8'd10, 8'd5, 4'd5, 8'h00, 8'h00);
        chk("full_busy2", 32'(bus.busy), 1);
        issue(8'h04, 8'd7, 8'd7, 4'd6, 8'h00, 8'h00);
        chk("full_busy3", 32'(bus.busy), 1);
        chk("full_head_val", 32'(bus.value_out), 3);
        chk("full_head_id", 32'(bus.robid_out), 4);
        bus.cdb_transmit = 1'b0;
        bus.rob_transmit = 1'b0;
        step();
        chk("full_second_val", 32'(bus.value_out), 5);
        chk("full_second_id", 32'(bus.robid_out), 5);
        chk("full_second_busy", 32'(bus.busy), 0);
        step();
        chk_empty("full_drained");
        issue(8'h04, 8'd1, 8'd1, 4'd7, 8'h00, 8'h00);
        chk("tput_1", 32'(bus.value_out), 2);
        issue(8'h04, 8'd2, 8'd2, 4'd8, 8'h00, 8'h00);
        chk("tput_2", 32'(bus.value_out), 4);
        chk("tput_2_id", 32'(bus.robid_out), 8);
        chk("tput_busy", 32'(bus.busy), 0);
        step();
        op_chk("and", 8'h24, 8'hF0, 8'h3C, 8'h30);
        op_chk("or", 8'h34, 8'hF0, 8'h3C, 8'hFC);
        op_chk("xor", 8'h44, 8'hF0, 8'hFF, 8'h0F);
        op_chk("shl", 8'h54, 8'h81, 8'h01, 8'h02);
        op_chk("shr", 8'h64, 8'h81, 8'h01, 8'h40);
        op_chk("sra", 8'h74, 8'h81, 8'h01, 8'hC0);
        op_chk("slt", 8'h84, 8'hFF, 8'h01, 8'h01);
        op_chk("sltu", 8'h94, 8'hFF, 8'h01, 8'h00);
        op_chk("fn10", 8'hA4, 8'h12, 8'h34, 8'h00);
        issue(8'h05, 8'd1, 8'd1, 4'd1, 8'h00, 8'h00);
        chk_empty("nonalu");
        bus.cdb_transmit = 1'b1;
        bus.rob_transmit = 1'b1;
        issue(8'h04, 8'd1, 8'd1, 4'd1, 8'h11, 8'h00);
        issue(8'h04, 8'd2, 8'd2, 4'd2, 8'h22, 8'h00);
        chk("arst_busy_pre", 32'(bus.busy), 1);
        #3;
        rst = 1'b1;
        #1;
        chk_empty("arst");
        chk("arst_wbs", 32'(bus.wbs_out), 0);
        chk("arst_id", 32'(bus.cdb_id), 0);
        step();
        rst = 1'b0;
        bus.cdb_transmit = 1'b0;
        bus.rob_transmit = 1'b0;
        step();
        chk_empty("arst_after");
        issue(8'h04, 8'd5, 8'd5, 4'd3, 8'h00, 8'h00);
        chk("arst_reuse", 32'(bus.value_out), 10);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
